mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Iterative signed MULT/DIV engine that answers the multicycle control unit.
- The control unit issues a start pulse with operands A/B. This block runs the operation and returns HI/LO with a one-cycle done pulse and a divide-by-zero flag.
- The control unit waits on done before asserting HiLoWrite, then branches to its exception states on div_zero.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; the only clock is clk.
- start  in  1  request, sampled only in IDLE.
- op  in  1  0 = MULT, 1 = DIV.
- a  in  WIDTH  multiplicand or dividend (register A), signed.
- b  in  WIDTH  multiplier or divisor (register B), signed.
- hi  out  WIDTH  MULT: upper product; DIV: remainder.
- lo  out  WIDTH  MULT: lower product; DIV: quotient.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  high with done when DIV had b == 0.

Behaviour:
- Reset (reset == 0 at a clk edge): state = IDLE; hi = lo = 0; busy = done = div_zero = 0; counter and work registers cleared. Reset overrides everything, including mid-operation: no done is issued and hi/lo read 0.
- States:
  - IDLE -> MULT on start & op == 0.
  - IDLE -> DIV on start & op == 1 & b != 0.
  - IDLE -> DONE on start & op == 1 & b == 0.
  - MULT -> FIX after WIDTH iterations; DIV -> FIX after WIDTH iterations.
  - FIX -> DONE.
  - DONE -> IDLE.
- Start capture: at the start edge, latch op, the operand signs, and the magnitudes |a| and |b| as WIDTH-bit unsigned. |0x80000000| = 0x80000000.
- MULT: shift-add on magnitudes. Each cycle, if the product LSB is set, add the multiplicand to the upper half with a WIDTH+1 carry, then shift right 1.
- DIV: restoring division. Each cycle, shift {rem, quo} left 1, trial-subtract the divisor. If the result is non-negative, keep it and set the quotient LSB.
- FIX:
  - MULT: negate the 2*WIDTH product if sign(a) ^ sign(b).
  - DIV: negate the quotient if sign(a) ^ sign(b); negate the remainder if sign(a).
  - Quotient truncates toward zero. 0x80000000 / -1 gives lo = 0x80000000, hi = 0 (no overflow trap).
  - hi/lo are registered on the FIX -> DONE edge.
- Timing (start sampled at edge E0):
  - busy = 1 during MULT/DIV/FIX, i.e. E0..E(WIDTH+1).
  - done = 1 in the DONE cycle, E(WIDTH+1)..E(WIDTH+2), giving 33-cycle latency at WIDTH = 32.
- Divide by zero: IDLE -> DONE directly. done = div_zero = 1 for the one cycle after E0; hi/lo keep their previous values.
- Hold and inputs:
  - hi/lo hold their values until the next completion.
  - start asserted outside IDLE is ignored.
  - a, b and op may change after E0 without effect.
- Outputs: done and div_zero are 0 in every state except DONE. busy is 0 in IDLE and DONE.

Optional Feature:
- MULTDIV_FAST_MULT_EN defined: MULT computes the product with a single-cycle signed multiply in the MULT state, then goes MULT -> DONE. busy lasts 1 cycle and done is asserted in the cycle after E1. DIV is unchanged.
- Undefined: WIDTH-iteration shift-add MULT as above.

Decomposition:
- multdiv_pkg holds:
  - the state encoding (IDLE, MULT, DIV, FIX, DONE);
  - the op encodings OP_MULT = 0, OP_DIV = 1;
  - the default WIDTH constant.
- One sub-module, div_step: combinational single restoring-division step. Inputs: rem, quotient MSB, divisor. Outputs: next rem and quotient bit. It is instantiated once in the DIV datapath.

Test Plan:
- MULT a=7, b=-3 (0xFFFFFFFD) -> after 33 cycles: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB, div_zero=0.
- MULT a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV a=5, b=0 with prior hi/lo = 0x11/0x22 -> done=div_zero=1 in the cycle after start; hi/lo stay 0x11/0x22; busy never 1.
- MULT started; start re-pulsed with op=1 at iteration 5; reset=0 at iteration 10 -> second start ignored; after reset: busy=0, hi=lo=0, and no done pulse.
- With MULTDIV_FAST_MULT_EN: MULT 7 * -3 -> done in the cycle after E1, same hi/lo as scenario 1.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative MULT/DIV engine.
//   state_t       : controller states (IDLE, MULT, DIV, FIX, DONE)
//   OP_MULT/OP_DIV: op input encodings
//   DEFAULT_WIDTH : default operand width
package multdiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int unsigned DEFAULT_WIDTH = 32;

endpackage

// File: rtl/mult_div_unit_div_step.sv
// div_step: one combinational restoring-division step.
// Ports:
//   rem      : current partial remainder (unsigned magnitude)
//   q_msb    : dividend/quotient register MSB shifted into the remainder
//   divisor  : divisor magnitude
//   rem_next : partial remainder after the trial subtraction
//   q_bit    : quotient bit produced by this step
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < divisor always holds, so the shifted value fits in WIDTH+1 bits
    // and a kept difference always fits back into WIDTH bits.
    always_comb begin
        shifted = {rem, q_msb};
        diff    = shifted - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            rem_next = diff[WIDTH-1:0];
            q_bit    = 1'b1;
        end else begin
            rem_next = shifted[WIDTH-1:0];
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed MULT/DIV engine for the multicycle control unit.
// Ports:
//   clk, reset (sync, active-low)
//   start, op (0 = MULT, 1 = DIV), a, b : request and signed operands
//   hi, lo   : MULT upper/lower product, DIV remainder/quotient
//   busy     : operation in progress (MULT/DIV/FIX)
//   done     : one-cycle completion pulse
//   div_zero : with done when a DIV had b == 0
// Build option: MULTDIV_FAST_MULT_EN selects a single-cycle multiply for MULT.
module mult_div_unit
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    state_t state, state_next;

    logic [CNT_W-1:0]   cnt;
    logic               op_r;
    logic               neg_res;
    logic               neg_rem;
    logic               dz_r;
    logic [WIDTH-1:0]   bmag;
    logic [WIDTH-1:0]   work_hi;
    logic [WIDTH-1:0]   work_lo;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   div_rem_next;
    logic               div_qbit;
    logic               last_iter;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fix;

    // Two's-complement negate of the most negative value returns itself,
    // which is exactly its unsigned magnitude.
    assign a_mag     = a[WIDTH-1] ? -a : a;
    assign b_mag     = b[WIDTH-1] ? -b : b;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

`ifdef MULTDIV_FAST_MULT_EN
    assign prod_mag = {{WIDTH{1'b0}}, bmag} * {{WIDTH{1'b0}}, work_lo};
`else
    logic [WIDTH:0] mult_sum;
    assign mult_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, bmag} : '0);
    assign prod_mag = {work_hi, work_lo};
`endif

    assign prod_fix = neg_res ? -prod_mag : prod_mag;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (work_hi),
        .q_msb    (work_lo[WIDTH-1]),
        .divisor  (bmag),
        .rem_next (div_rem_next),
        .q_bit    (div_qbit)
    );

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        div_zero   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MULT)
                        state_next = S_MULT;
                    else if (b == '0)
                        state_next = S_DONE;
                    else
                        state_next = S_DIV;
                end
            end
            S_MULT: begin
                busy = 1'b1;
`ifdef MULTDIV_FAST_MULT_EN
                state_next = S_DONE;
`else
                if (last_iter)
                    state_next = S_FIX;
`endif
            end
            S_DIV: begin
                busy = 1'b1;
                if (last_iter)
                    state_next = S_FIX;
            end
            S_FIX: begin
                busy       = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                div_zero   = dz_r;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            op_r    <= OP_MULT;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz_r    <= 1'b0;
            bmag    <= '0;
            work_hi <= '0;
            work_lo <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_r    <= op;
                        neg_res <= a[WIDTH-1] ^ b[WIDTH-1];
                        neg_rem <= a[WIDTH-1];
                        dz_r    <= (op == OP_DIV) && (b == '0);
                        bmag    <= b_mag;
                        work_hi <= '0;
                        work_lo <= a_mag;
                        cnt     <= '0;
                    end
                end
                S_MULT: begin
`ifdef MULTDIV_FAST_MULT_EN
                    hi <= prod_fix[2*WIDTH-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
`else
                    // Shift-add: the bit shifted out of the sum carries into lo.
                    cnt     <= cnt + CNT_W'(1);
                    work_hi <= mult_sum[WIDTH:1];
                    work_lo <= {mult_sum[0], work_lo[WIDTH-1:1]};
`endif
                end
                S_DIV: begin
                    cnt     <= cnt + CNT_W'(1);
                    work_hi <= div_rem_next;
                    work_lo <= {work_lo[WIDTH-2:0], div_qbit};
                end
                S_FIX: begin
                    if (op_r == OP_MULT) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else begin
                        lo <= neg_res ? -work_lo : work_lo;
                        hi <= neg_rem ? -work_hi : work_hi;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
